// File: rtl/tone_meter_pkg.sv
// Shared definitions for the buzzer tone path: game tone table, widths and the
// frequency-to-tone classifier used by the game top and the tone meter.
package tone_meter_pkg;

    localparam int FREQ_W     = 10;
    localparam int TONE_IDX_W = 2;
    localparam int NUM_TONES  = 4;

    localparam logic [FREQ_W-1:0] FREQ_MAX = 10'd1023;
    localparam logic [FREQ_W-1:0] GAME_TONES [NUM_TONES] = '{10'd196, 10'd262, 10'd330, 10'd784};

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } meter_state_t;

    typedef struct packed {
        logic                  hit;
        logic [TONE_IDX_W-1:0] idx;
    } tone_match_t;

    // Scan from the top index down so the lowest matching index is the one kept.
    function automatic tone_match_t classify_tone(input logic [FREQ_W-1:0] freq, input int tol);
        tone_match_t          m;
        logic signed [FREQ_W+1:0] diff;
        m = '0;
        for (int i = NUM_TONES - 1; i >= 0; i--) begin
            diff = $signed({2'b00, freq}) - $signed({2'b00, GAME_TONES[i]});
            if (diff < 0) diff = -diff;
            if (int'(diff) <= tol) begin
                m.hit = 1'b1;
                m.idx = TONE_IDX_W'(i);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/tone_meter_if.sv
// Sound-line tap and measurement results of the tone meter.
interface tone_meter_if;
    import tone_meter_pkg::*;

    logic [15:0]           ticks_per_milli;
    logic                  sound_in;
    logic [FREQ_W-1:0]     freq_out;
    logic                  freq_valid;
    logic                  present;
    logic                  tone_hit;
    logic [TONE_IDX_W-1:0] tone_idx;

    modport master (
        output ticks_per_milli, sound_in,
        input  freq_out, freq_valid, present, tone_hit, tone_idx
    );

    modport slave (
        input  ticks_per_milli, sound_in,
        output freq_out, freq_valid, present, tone_hit, tone_idx
    );

endinterface

// File: rtl/tone_meter_udiv32_seq.sv
// Restoring 32/32 unsigned divider, one quotient bit per cycle, start-to-done 32 cycles.
// The first bit is resolved in the load cycle; a zero divisor yields an all-ones quotient.
module udiv32_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient
);

    logic [31:0] rem_q, quo_q, den_q;
    logic [31:0] rem_in, quo_in, den_in;
    logic [31:0] rem_nxt, quo_nxt;
    logic [4:0]  cnt_q;
    logic        load;

    function automatic logic [63:0] div_step(input logic [31:0] rem, input logic [31:0] quo,
                                             input logic [31:0] den);
        logic [32:0] shifted;
        logic [32:0] trial;
        shifted = {rem, quo[31]};
        trial   = shifted - {1'b0, den};
        if (den == '0 || !trial[32])
            return {trial[31:0], quo[30:0], 1'b1};
        else
            return {shifted[31:0], quo[30:0], 1'b0};
    endfunction

    assign load = start && !busy && !abort;

    always_comb begin
        rem_in = load ? 32'd0    : rem_q;
        quo_in = load ? dividend : quo_q;
        den_in = load ? divisor  : den_q;
        {rem_nxt, quo_nxt} = div_step(rem_in, quo_in, den_in);
    end

    always_ff @(posedge clk) begin
        if (load || busy) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
        end
        if (load) den_q <= divisor;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt_q <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
            end else if (load) begin
                busy  <= 1'b1;
                cnt_q <= 5'd1;
            end else if (busy) begin
                cnt_q <= cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/tone_meter.sv
// Square-wave frequency meter: averages AVG_PERIODS input periods, divides the
// window length into the clock rate, and classifies the result against the game tones.
module tone_meter
    import tone_meter_pkg::*;
#(
    parameter int AVG_PERIODS = 4,
    parameter int TIMEOUT_MS  = 50,
    parameter int TOL_HZ      = 8
) (
    input  logic          clk,
    input  logic          rst,
    tone_meter_if.slave   bus
);

    localparam int EDGE_W = 5;

    meter_state_t state, state_nxt;

    logic        sync_p0, sync_p1, prev_p2, rise_p2;
    logic [15:0] tick_cnt, ms_cnt;
    logic        timeout;
    logic [31:0] win_cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic        win_clr, close, edge_inc, launch;
    logic [31:0] divisor, dividend;
    logic        vld_p3;
    logic [31:0] div_num_p3, div_den_p3;
    logic        div_busy, div_done;
    logic [31:0] div_quo;
    logic [FREQ_W-1:0]     freq_q, freq_sat;
    logic                  valid_q, present_q, hit_q;
    logic [TONE_IDX_W-1:0] idx_q;
    tone_match_t           match;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    function automatic logic [FREQ_W-1:0] sat_freq(input logic [31:0] q);
        return (q > 32'(FREQ_MAX)) ? FREQ_MAX : q[FREQ_W-1:0];
    endfunction

    // Stage p0/p1: synchronizer; stage p2: registered rising-edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
            rise_p2 <= 1'b0;
        end else begin
            sync_p0 <= bus.sound_in;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
            rise_p2 <= sync_p1 && !prev_p2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rise_p2) begin
            tick_cnt <= '0;
            ms_cnt   <= '0;
        end else if (tick_cnt == bus.ticks_per_milli - 16'd1) begin
            tick_cnt <= '0;
            if (ms_cnt != 16'(TIMEOUT_MS)) ms_cnt <= ms_cnt + 16'd1;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    assign timeout = (ms_cnt == 16'(TIMEOUT_MS)) && !rise_p2;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        win_clr   = 1'b0;
        close     = 1'b0;
        edge_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise_p2) begin
                    win_clr   = 1'b1;
                    state_nxt = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (rise_p2) begin
                    if (edge_cnt == EDGE_W'(AVG_PERIODS - 1)) close    = 1'b1;
                    else                                      edge_inc = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (timeout) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
        end else if (win_clr || close) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
        end else if (state == ST_MEASURE) begin
            win_cnt <= sat_inc32(win_cnt);
            if (edge_inc) edge_cnt <= edge_cnt + EDGE_W'(1);
        end
    end

    // The closing cycle is part of the window; the half-divisor bias rounds to nearest.
    assign divisor  = sat_inc32(win_cnt);
    assign dividend = 32'(bus.ticks_per_milli) * 32'(AVG_PERIODS * 1000) + (divisor >> 1);
    assign launch   = close && !div_busy && !vld_p3;

    // Stage p3: divider operands and start strobe
    always_ff @(posedge clk) begin
        if (rst) vld_p3 <= 1'b0;
        else     vld_p3 <= launch;
    end

    always_ff @(posedge clk) begin
        if (launch) begin
            div_num_p3 <= dividend;
            div_den_p3 <= divisor;
        end
    end

    udiv32_seq u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (vld_p3),
        .abort    (timeout),
        .dividend (div_num_p3),
        .divisor  (div_den_p3),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    assign freq_sat = sat_freq(div_quo);
    assign match    = classify_tone(freq_sat, TOL_HZ);

    // Result stage: captured the cycle after done
    always_ff @(posedge clk) begin
        if (rst) begin
            freq_q    <= '0;
            valid_q   <= 1'b0;
            present_q <= 1'b0;
            hit_q     <= 1'b0;
            idx_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            if (timeout) begin
                freq_q    <= '0;
                present_q <= 1'b0;
                hit_q     <= 1'b0;
                idx_q     <= '0;
            end else if (div_done) begin
                freq_q    <= freq_sat;
                valid_q   <= 1'b1;
                present_q <= 1'b1;
                hit_q     <= match.hit;
                idx_q     <= match.idx;
            end
        end
    end

    assign bus.freq_out   = freq_q;
    assign bus.freq_valid = valid_q;
    assign bus.present    = present_q;
    assign bus.tone_hit   = hit_q;
    assign bus.tone_idx   = idx_q;

endmodule

// File: tb/tb_tone_meter.sv
// Directed bench for tone_meter at 50 ticks per ms: frequency, latency, saturation,
// tone matching, timeout and reset-during-divide.
module tb_tone_meter;
    import tone_meter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;
    int   last_rise = 0;

    int   valid_cnt = 0;
    int   valid_cyc [256];
    int   valid_frq [256];

    always #5 clk = ~clk;

    tone_meter_if bus ();

    tone_meter #(.AVG_PERIODS(4), .TIMEOUT_MS(50), .TOL_HZ(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.freq_valid === 1'b1) begin
            valid_cyc[valid_cnt % 256] <= cyc;
            valid_frq[valid_cnt % 256] <= int'(bus.freq_out);
            valid_cnt <= valid_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // All stimulus tasks start and end 1 time unit after a rising clock edge.
    task automatic to_phase();
        @(posedge clk);
        #1;
    endtask

    task automatic send_period(input int period);
        bus.sound_in = 1'b1;
        last_rise = cyc;
        repeat (period / 2) @(posedge clk);
        #1 bus.sound_in = 1'b0;
        repeat (period - period / 2) @(posedge clk);
        #1;
    endtask

    task automatic hold_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic check_steady(input string tag, input int freq, input int hit, input int idx);
        check({tag, "_freq_out"}, 32'(bus.freq_out), 32'(freq));
        check({tag, "_last_valid"}, 32'(valid_frq[(valid_cnt - 1) % 256]), 32'(freq));
        check({tag, "_present"}, 32'(bus.present), 32'd1);
        check({tag, "_tone_hit"}, 32'(bus.tone_hit), 32'(hit));
        check({tag, "_tone_idx"}, 32'(bus.tone_idx), 32'(idx));
    endtask

    initial begin
        int base;
        int p5;
        int ld;
        int n0;
        int f;

        bus.ticks_per_milli = 16'd50;
        bus.sound_in        = 1'b0;
        rst                 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_freq_out",   32'(bus.freq_out),   32'd0);
        check("rst_freq_valid", 32'(bus.freq_valid), 32'd0);
        check("rst_present",    32'(bus.present),    32'd0);
        check("rst_tone_hit",   32'(bus.tone_hit),   32'd0);
        check("rst_tone_idx",   32'(bus.tone_idx),   32'd0);
        to_phase();
        rst = 1'b0;

        // 500 Hz: 400-cycle window, 200200/400 = 500
        base = valid_cnt;
        p5   = 0;
        for (int i = 0; i < 10; i++) begin
            send_period(100);
            if (i == 4) p5 = last_rise;
        end
        hold_cycles(40);
        check("s1_present_before_any", 32'(valid_cnt > base), 32'd1);
        check("s1_latency", 32'(valid_cyc[base % 256]), 32'(p5 + 37));
        check("s1_first_freq", 32'(valid_frq[base % 256]), 32'd500);
        check_steady("s1", 500, 0, 0);

        // 191-cycle period: 200382/764 = 262
        for (int i = 0; i < 12; i++) send_period(191);
        hold_cycles(40);
        check_steady("s2", 262, 1, 1);

        // 64-cycle period: 200128/256 = 781, 3 Hz from 784
        for (int i = 0; i < 12; i++) send_period(64);
        hold_cycles(40);
        check_steady("s3", 781, 1, 3);

        // 10-cycle period: 5000 Hz saturates
        for (int i = 0; i < 20; i++) send_period(10);
        hold_cycles(40);
        check_steady("s4", 1023, 0, 0);

        // Timeout: ms counter reaches 50 in detect cycle + 2501
        for (int i = 0; i < 8; i++) send_period(100);
        ld = last_rise;
        wait_until(ld + 2504);
        check("s5_present_before_timeout", 32'(bus.present), 32'd1);
        check("s5_freq_before_timeout", 32'(bus.freq_out), 32'd500);
        n0 = valid_cnt;
        wait_until(ld + 2505);
        check("s5_present_after_timeout", 32'(bus.present), 32'd0);
        check("s5_freq_after_timeout", 32'(bus.freq_out), 32'd0);
        check("s5_hit_after_timeout", 32'(bus.tone_hit), 32'd0);
        wait_until(ld + 2700);
        check("s5_no_valid_pulse", 32'(valid_cnt), 32'(n0));
        to_phase();

        base = valid_cnt;
        for (int i = 0; i < 10; i++) begin
            send_period(100);
            if (i == 4) p5 = last_rise;
        end
        hold_cycles(40);
        check("s5_restart_latency", 32'(valid_cyc[base % 256]), 32'(p5 + 37));
        check("s5_restart_freq", 32'(valid_frq[base % 256]), 32'd500);
        check("s5_restart_present", 32'(bus.present), 32'd1);

        // Reset in the middle of a divide
        rst = 1'b1;
        hold_cycles(2);
        rst = 1'b0;
        base = valid_cnt;
        for (int i = 0; i < 4; i++) send_period(100);
        bus.sound_in = 1'b1;
        p5 = cyc;
        hold_cycles(15);
        rst = 1'b1;
        hold_cycles(2);
        @(negedge clk);
        check("s6_rst_freq_out", 32'(bus.freq_out), 32'd0);
        check("s6_rst_present",  32'(bus.present),  32'd0);
        check("s6_rst_tone_idx", 32'(bus.tone_idx), 32'd0);
        to_phase();
        rst = 1'b0;
        bus.sound_in = 1'b0;
        wait_until(p5 + 80);
        check("s6_no_stale_pulse", 32'(valid_cnt), 32'(base));
        to_phase();

        // 330 Hz from alternating 152/151-cycle periods: 200303/606 = 330
        for (int i = 0; i < 8; i++) begin
            send_period(152);
            send_period(151);
        end
        hold_cycles(40);
        f = int'(bus.freq_out);
        check("s6_freq_in_range", 32'((f >= 328) && (f <= 332)), 32'd1);
        check("s6_got_valid", 32'(valid_cnt > base), 32'd1);
        check("s6_present", 32'(bus.present), 32'd1);
        check("s6_tone_hit", 32'(bus.tone_hit), 32'd1);
        check("s6_tone_idx", 32'(bus.tone_idx), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/tone_meter.md
Name: tone_meter

Overview:
- Receive end of the buzzer square-wave link. Measures the frequency of a 1-bit square wave, such as the output of the game's tone player, and reports it in Hz.
- Classifies the measured frequency against the four game tones.
- Used as a self-check monitor on the board and as a scoreboard front-end in simulation. It sits beside the game top and taps the sound line.

Parameters:
- AVG_PERIODS, 4, number of full input periods per measurement window (power of two, 1..16).
- TIMEOUT_MS, 50, ms without a rising edge before the tone is declared absent.
- TOL_HZ, 8, maximum |freq - tone| for a tone match.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- ticks_per_milli  in  16  clk cycles per millisecond (50 on the board). Static while out of reset.
- sound_in  in  1  square wave under measurement. May be asynchronous.
- freq_out  out  10  last measured frequency in Hz, saturated at 1023. 0 when absent.
- freq_valid  out  1  one-cycle pulse when freq_out is updated with a new measurement.
- present  out  1  high while edges arrive within TIMEOUT_MS.
- tone_hit  out  1  freq_out is within TOL_HZ of a game tone.
- tone_idx  out  2  index of the matched tone. 0 when tone_hit=0.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; window, ms and edge counters cleared; divider idle, result discarded.
- Input path: 2-FF synchronizer, then a registered rising-edge detector. An edge is seen 3 cycles after the sound_in transition.
- Timebase: tick counter wraps at ticks_per_milli-1 and increments a ms-since-last-edge counter. Any rising edge clears both.
- FSM IDLE: wait for a rising edge. On the edge: clear the window tick counter and edge count, then go to MEASURE.
- FSM MEASURE:
  - Window counter (32 bit, saturating) increments every cycle.
  - Each rising edge increments the edge count.
  - On the AVG_PERIODS-th edge: latch the divisor = window count including that cycle, start the divider, and restart the window at 0. The closing edge opens the next window; stay in MEASURE.
  - Edges arriving during a divide count toward the next window.
  - If a window closes while the divider is busy, drop that window's result (no restart).
- Divider inputs:
  - dividend = ticks_per_milli*1000*AVG_PERIODS + (divisor>>1), giving round-to-nearest. 32-bit unsigned arithmetic.
  - A divisor of 0 cannot occur; the divider treats it as quotient all-ones.
- Divider timing: fixed latency of 32 cycles, start to done.
- Result register, on the cycle after done:
  - freq_out = min(quotient, 1023); freq_valid=1 for one cycle; present=1.
  - tone_hit and tone_idx are updated in the same cycle.
  - Latency: edge-detect cycle E, start at E+1, done at E+33, outputs and pulse at E+34.
- Classification: compare the saturated value against GAME_TONES {196, 262, 330, 784}. The tones do not overlap for TOL_HZ<32; on a tie, the lowest index wins.
- Timeout (any state):
  - Trigger: the ms counter reaches TIMEOUT_MS with no edge.
  - Effect: present, freq_out, tone_hit and tone_idx go to 0 the next cycle. No freq_valid pulse. Any in-flight divide is aborted and its result discarded. FSM returns to IDLE.
- present rises only with the first freq_valid, never on a lone edge.
- rst asserted mid-window or mid-divide: the reset state is applied on the next edge of clk; no partial result is emitted.

Decomposition:
- Shared package: GAME_TONES array (196, 262, 330, 784), tone index width (2), frequency width (10), FREQ_MAX=1023. The game top and this block both use it.
- One sub-module, udiv32_seq:
  - Restoring 32/32 divider with start/busy/done handshake and 32-cycle latency.
  - Abort input clears busy with no done.

Test Plan (ticks_per_milli=50):
1. Ideal 500 Hz square wave (period 100 clk) -> first freq_valid 34 cycles after the 5th rising edge; freq_out=500, present=1, tone_hit=0.
2. Period 191 clk (~262 Hz) -> freq_out=262, tone_hit=1, tone_idx=1.
3. Period 64 clk -> freq_out=781, tone_hit=1, tone_idx=3.
4. Period 10 clk (5000 Hz) -> freq_out=1023 (saturated), tone_hit=0.
5. Toggle at 500 Hz, then hold sound_in low -> 2500 clk after the last edge, present=0, freq_out=0, no freq_valid; restarting the toggle reproduces scenario 1.
6. Assert rst during a divide, then apply a 330 Hz wave from the tone player (freq=330) -> no stale pulse; freq_out settles in 328..332, tone_idx=2.
